// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the NZCV flag register, resolves ARM condition codes,
// and issues a registered fetch redirect with a post-redirect wrong-path squash window.
module branch_resolve_unit #(
    parameter int ADDR_W    = 64,
    parameter int OFF_W     = 26,
    parameter int SQUASH    = 2,
    parameter int FWD_FLAGS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flag_we,
    input  logic [3:0]        flags_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              br_uncond,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              flush,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_squashed,
    output logic [3:0]        flags_q,
    output logic              squash_active
);

    localparam int CNT_W = (SQUASH > 0) ? $clog2(SQUASH + 1) : 1;

    logic [3:0]        nzcv_q;
    logic              rvld_q, res_vld_q, res_tkn_q, res_sq_q;
    logic [ADDR_W-1:0] rpc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [3:0]        eval_flags;
    logic              cond_ok, taken, accept, rdone, new_redir, sq;
    logic [ADDR_W-1:0] off_sext, target;

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        unique case (cc)
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = !c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = c & !z;
            4'h9: cond_pass = !c | z;
            4'ha: cond_pass = (n == v);
            4'hb: cond_pass = (n != v);
            4'hc: cond_pass = !z & (n == v);
            4'hd: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;  // AL and NV both always execute
        endcase
    endfunction

    assign eval_flags = ((FWD_FLAGS != 0) && flag_we) ? flags_in : nzcv_q;
    assign cond_ok    = cond_pass(br_cond, eval_flags);
    assign taken      = br_uncond | cond_ok;

    assign off_sext   = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign target     = br_pc + {off_sext[ADDR_W-3:0], 2'b00};

    assign br_ready   = !rvld_q | redirect_ready;
    assign accept     = br_valid & br_ready;
    assign rdone      = rvld_q & redirect_ready;
    assign sq         = (cnt_q != '0);
    // Squash is judged on the pre-edge counter, so a branch accepted alongside
    // a completing redirect is resolved before the new window opens.
    assign new_redir  = accept & !sq & taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_q    <= '0;
            rvld_q    <= 1'b0;
            rpc_q     <= '0;
            res_vld_q <= 1'b0;
            res_tkn_q <= 1'b0;
            res_sq_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (flag_we)
                nzcv_q <= flags_in;
            if (flush) begin
                rvld_q    <= 1'b0;
                res_vld_q <= 1'b0;
                res_tkn_q <= 1'b0;
                res_sq_q  <= 1'b0;
                cnt_q     <= '0;
            end else begin
                res_vld_q <= accept;
                res_sq_q  <= accept & sq;
                res_tkn_q <= new_redir;
                if (new_redir) begin
                    rvld_q <= 1'b1;
                    rpc_q  <= target;
                end else if (rdone) begin
                    rvld_q <= 1'b0;
                end
                if (rdone)
                    cnt_q <= CNT_W'(SQUASH);
                else if (sq)
                    cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign flags_q        = nzcv_q;
    assign redirect_valid = rvld_q;
    assign redirect_pc    = rpc_q;
    assign res_valid      = res_vld_q;
    assign res_taken      = res_tkn_q;
    assign res_squashed   = res_sq_q;
    assign squash_active  = sq;

endmodule
